// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blanking
// and a one-cycle frame tick, all aligned to the counters they accompany.
module vga_timing_gen #(
    parameter int H_VIS    = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_VIS    = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        frame_tick
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOT - 1);
    localparam logic [10:0] H_VIS_C      = 11'(H_VIS);
    localparam logic [10:0] H_SYNC_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_C      = 11'(V_VIS);
    localparam logic [10:0] V_SYNC_START = 11'(V_VIS + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic        POL          = (SYNC_POL != 0);

    logic [10:0] hcount_reg, hcount_next;
    logic [10:0] vcount_reg, vcount_next;
    logic        hsync_reg, hsync_next;
    logic        hblnk_reg, hblnk_next;
    logic        vsync_reg, vsync_next;
    logic        vblnk_reg, vblnk_next;
    logic        tick_reg, tick_next;

    // Flags are derived from the counter values about to be loaded so that
    // every output register describes the same pixel.
    always_comb begin
        hcount_next = hcount_reg + 11'd1;
        vcount_next = vcount_reg;
        if (hcount_reg == H_LAST) begin
            hcount_next = '0;
            vcount_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + 11'd1;
        end
        hblnk_next = (hcount_next >= H_VIS_C);
        hsync_next = ((hcount_next >= H_SYNC_START) && (hcount_next < H_SYNC_END)) ? POL : ~POL;
        vblnk_next = (vcount_next >= V_VIS_C);
        vsync_next = ((vcount_next >= V_SYNC_START) && (vcount_next < V_SYNC_END)) ? POL : ~POL;
        tick_next  = (hcount_next == H_LAST) && (vcount_next == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
            hblnk_reg  <= 1'b0;
            vblnk_reg  <= 1'b0;
            hsync_reg  <= ~POL;
            vsync_reg  <= ~POL;
            tick_reg   <= 1'b0;
        end else if (pix_en) begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
            hblnk_reg  <= hblnk_next;
            vblnk_reg  <= vblnk_next;
            hsync_reg  <= hsync_next;
            vsync_reg  <= vsync_next;
            tick_reg   <= tick_next;
        end else begin
            // A stalled cycle at the last pixel must not repeat the tick.
            tick_reg   <= 1'b0;
        end
    end

    assign hcount_out = hcount_reg;
    assign vcount_out = vcount_reg;
    assign hsync_out  = hsync_reg;
    assign hblnk_out  = hblnk_reg;
    assign vsync_out  = vsync_reg;
    assign vblnk_out  = vblnk_reg;
    assign frame_tick = tick_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance and two reduced-timing
// instances (both sync polarities) checked every cycle against a raster model.
module tb_vga_timing_gen;
    // Reduced timing so whole frames fit in a short run.
    localparam int S_HV = 20, S_HF = 3, S_HS = 5, S_HB = 4;
    localparam int S_VV = 10, S_VF = 1, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;   // 32
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;   // 16
    localparam int S_TOT = S_HT * S_VT;                // 512
    localparam int D_HT = 1056, D_VT = 628;
    localparam int D_TOT = D_HT * D_VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b1;

    logic [10:0] h_d, v_d, h_a, v_a, h_b, v_b;
    logic hs_d, hb_d, vs_d, vb_d, tk_d;
    logic hs_a, hb_a, vs_a, vb_a, tk_a;
    logic hs_b, hb_b, vs_b, vb_b, tk_b;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcount_out(h_d), .hsync_out(hs_d), .hblnk_out(hb_d),
        .vcount_out(v_d), .vsync_out(vs_d), .vblnk_out(vb_d), .frame_tick(tk_d)
    );

    vga_timing_gen #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcount_out(h_a), .hsync_out(hs_a), .hblnk_out(hb_a),
        .vcount_out(v_a), .vsync_out(vs_a), .vblnk_out(vb_a), .frame_tick(tk_a)
    );

    vga_timing_gen #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(0)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcount_out(h_b), .hsync_out(hs_b), .hblnk_out(hb_b),
        .vcount_out(v_b), .vsync_out(vs_b), .vblnk_out(vb_b), .frame_tick(tk_b)
    );

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a linear pixel index within the frame; position and flags follow
    // from division/modulo and the interval rules.
    int  p_s = 0, p_d = 0;
    bit  t_s = 0, t_d = 0;
    bit  valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            p_s <= 0; p_d <= 0; t_s <= 0; t_d <= 0; valid <= 1;
        end else if (pix_en) begin
            p_s <= (p_s + 1) % S_TOT;
            p_d <= (p_d + 1) % D_TOT;
            t_s <= (p_s == S_TOT - 2);
            t_d <= (p_d == D_TOT - 2);
        end else begin
            t_s <= 0; t_d <= 0;
        end
    end

    function automatic int in_rng(input int x, input int lo, input int n);
        return (x >= lo && x < lo + n) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            int hs, vs, hd, vd;
            hs = p_s % S_HT; vs = p_s / S_HT;
            hd = p_d % D_HT; vd = p_d / D_HT;
            chk("d_h", int'(h_d), hd);
            chk("d_v", int'(v_d), vd);
            chk("d_hblnk", int'(hb_d), (hd >= 800) ? 1 : 0);
            chk("d_hsync", int'(hs_d), in_rng(hd, 840, 128));
            chk("d_vblnk", int'(vb_d), (vd >= 600) ? 1 : 0);
            chk("d_vsync", int'(vs_d), in_rng(vd, 601, 4));
            chk("d_tick", int'(tk_d), int'(t_d));
            chk("a_h", int'(h_a), hs);
            chk("a_v", int'(v_a), vs);
            chk("a_hblnk", int'(hb_a), (hs >= S_HV) ? 1 : 0);
            chk("a_hsync", int'(hs_a), in_rng(hs, S_HV + S_HF, S_HS));
            chk("a_vblnk", int'(vb_a), (vs >= S_VV) ? 1 : 0);
            chk("a_vsync", int'(vs_a), in_rng(vs, S_VV + S_VF, S_VS));
            chk("a_tick", int'(tk_a), int'(t_s));
            chk("b_h", int'(h_b), hs);
            chk("b_v", int'(v_b), vs);
            chk("b_hblnk", int'(hb_b), (hs >= S_HV) ? 1 : 0);
            chk("b_hsync", int'(hs_b), 1 - in_rng(hs, S_HV + S_HF, S_HS));
            chk("b_vblnk", int'(vb_b), (vs >= S_VV) ? 1 : 0);
            chk("b_vsync", int'(vs_b), 1 - in_rng(vs, S_VV + S_VF, S_VS));
            chk("b_tick", int'(tk_b), int'(t_s));
        end
    end

    task automatic step(input logic r, input logic e);
        rst = r;
        pix_en = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hs_cnt, tick_cnt, vs_cnt, first_tick, last_tick;

        // Reset, release, first steps
        repeat (3) step(1'b1, 1'b1);
        chk("lit_rst_h", int'(h_d), 0);
        chk("lit_rst_hsync_pos", int'(hs_d), 0);
        chk("lit_rst_hsync_neg", int'(hs_b), 1);
        chk("lit_rst_tick", int'(tk_a), 0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1);
            chk("lit_post_rst_h", int'(h_d), i);
        end

        // One full default line
        hs_cnt = 0;
        for (int i = 4; i <= 1056; i++) begin
            step(1'b0, 1'b1);
            if (hs_d) hs_cnt++;
            if (i == 799)  chk("lit_hblnk_799", int'(hb_d), 0);
            if (i == 800)  chk("lit_hblnk_800", int'(hb_d), 1);
            if (i == 839)  chk("lit_hsync_839", int'(hs_d), 0);
            if (i == 840)  chk("lit_hsync_840", int'(hs_d), 1);
            if (i == 967)  chk("lit_hsync_967", int'(hs_d), 1);
            if (i == 968)  chk("lit_hsync_968", int'(hs_d), 0);
            if (i == 1055) chk("lit_h_1055", int'(h_d), 1055);
        end
        chk("lit_wrap_h", int'(h_d), 0);
        chk("lit_wrap_v", int'(v_d), 1);
        chk("lit_hsync_len", hs_cnt, 128);

        // Three reduced frames: tick count, spacing, vsync length
        step(1'b1, 1'b1);
        tick_cnt = 0; vs_cnt = 0; first_tick = -1; last_tick = -1;
        for (int i = 1; i <= 3 * S_TOT; i++) begin
            step(1'b0, 1'b1);
            if (vs_a) vs_cnt++;
            if (tk_a) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = i;
                last_tick = i;
                chk("lit_tick_pos", int'(h_a) * 100 + int'(v_a), 31 * 100 + 15);
            end
        end
        chk("lit_tick_count", tick_cnt, 3);
        chk("lit_tick_first", first_tick, 511);
        chk("lit_tick_span", last_tick - first_tick, 2 * 512);
        chk("lit_vsync_len", vs_cnt, 3 * 2 * 32);

        // pix_en gating at the last pixel of the frame
        step(1'b1, 1'b1);
        repeat (511) step(1'b0, 1'b1);
        chk("lit_gate_tick_on", int'(tk_a), 1);
        repeat (2) begin
            step(1'b0, 1'b0);
            chk("lit_gate_hold_h", int'(h_a), 31);
            chk("lit_gate_hold_v", int'(v_a), 15);
            chk("lit_gate_tick_off", int'(tk_a), 0);
        end
        step(1'b0, 1'b1);
        chk("lit_gate_wrap", int'(h_a) + int'(v_a), 0);
        chk("lit_gate_tick_after", int'(tk_a), 0);

        // Randomized enables with occasional mid-frame resets
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                repeat (3) step(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                step(1'b0, 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
